dm_responder: RTL
=================

Name: dm_responder

Overview:
- Data-memory responder for the CPU's load/store port: the memory-side end of the `re`/`we`/`addr`/`wrt_data`/`rd_data` interface the CPU drives.
- Replaces the zero-latency data memory with a multi-cycle word store.
- Freezes the CPU with `stall` while an access is in flight, then presents the read data with a one-cycle `done` pulse.
- Sits between the CPU datapath and the on-chip data array.

Parameters:
- `ADDR_W`, 10, word-address bits used; `addr[ADDR_W-1:0]` indexes the array, upper bits ignored.
- `LATENCY`, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  16  word address (CPU ALU result)
- `re`  in  1  read request
- `we`  in  1  write request
- `wrt_data`  in  16  store data
- `rd_data`  out  16  load data, registered
- `stall`  out  1  CPU must hold PC and request; combinational
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky: `re` and `we` seen together

Behaviour:
- Reset (`rst` high at a rising edge):
  - state IDLE, `cnt` 0, `rd_data` 0x0000, `err` 0.
  - `stall` and `done` read 0 in the following cycle.
  - Array contents are not cleared.
- Reset mid-operation aborts the access. A write not yet committed is discarded, and no `done` is produced.
- States: IDLE, BUSY, DONE; 4-bit down-counter `cnt`.
- IDLE:
  - Request present (`re` or `we`): latch addr, data and op; `stall`=1 this cycle.
  - Next state is DONE if `LATENCY`==1, else BUSY with `cnt`=`LATENCY`-2.
  - No request: stay in IDLE, `stall`=0.
- BUSY: `stall`=1. If `cnt`==0, go to DONE; else decrement `cnt`. Inputs are ignored (the CPU is frozen).
- Commit happens on the clock edge entering DONE:
  - Write: array[latched addr] <= latched data.
  - Read: `rd_data` <= array[latched addr].
- DONE (exactly one cycle):
  - `stall`=0, `done`=1.
  - The still-presented request is the one just serviced and is not re-accepted.
  - Next state is always IDLE.
- Timing: request first presented in cycle 0 → `stall` high in cycles 0..`LATENCY`-1, `done` in cycle `LATENCY`.
- Sustained access rate is one per `LATENCY`+1 cycles. A request presented in the cycle after DONE is accepted normally.
- `rd_data` holds its value until the next read commit. Write completions leave it unchanged.
- `re`=`we`=1 in an accepting IDLE cycle:
  - The access is treated as a write.
  - `err` is set and stays set until `rst`.
- Address wrap: `addr` = 0x0400 with `ADDR_W`=10 aliases word 0.
- Read-after-write to the same address, back to back: the read returns the newly written value, because the write committed before the read was accepted.
- No combinational path from `rd_data` to `stall`. `stall` depends only on state, `re` and `we`.

Decomposition:
- Shared package `dm_pkg`:
  - state enum (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - `DM_WORD_W`=16;
  - `DM_LAT_MAX`=15.
- One natural sub-module, `dm_array`:
  - single-port 2^`ADDR_W` x 16 synchronous RAM;
  - inputs `we` and `addr`; registered read output.
- The responder owns the FSM, the counter, the request latch and the flags.

Test Plan:
- Reset then idle: `rst` for 2 cycles, no requests → `stall`=0, `done`=0, `rd_data`=0x0000, `err`=0.
- Write then read, `LATENCY`=2:
  - `we`, addr 0x0005, data 0xBEEF at cycle 0 → `stall` high in cycles 0–1, `done` in cycle 2.
  - `re` at 0x0005 in cycle 3 → `stall` in cycles 3–4, `done` in cycle 5, `rd_data`=0xBEEF.
- `LATENCY`=1: read of a preloaded word 0x1234 at addr 3 → `stall` high for cycle 0 only, `done` in cycle 1 with `rd_data`=0x1234. Back-to-back requests complete every 2 cycles.
- Aliasing: write 0xA5A5 to addr 0x0402, read addr 0x0002 → 0xA5A5.
- Conflict: `re`=`we`=1, addr 7, data 0x0F0F → treated as a write. `err`=1 from the next cycle; a subsequent read of addr 7 returns 0x0F0F; `err` stays 1 until `rst`.
- Reset mid-write: `we` to addr 9 with data 0x5555 (prior value 0x1111), `rst` during BUSY → no `done`, and a later read of addr 9 returns 0x1111.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder slice.
//   DM_WORD_W  : data word width
//   DM_LAT_MAX : largest supported access latency (4-bit down-counter)
//   dm_state_e : responder FSM states
package dm_pkg;
  localparam int DM_WORD_W  = 16;
  localparam int DM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;
endpackage

// File: rtl/dm_responder_if.sv
// CPU load/store port bundle.
//   master : CPU side (drives addr/re/we/wrt_data, sees rd_data/stall/done/err)
//   slave  : memory responder side
interface dm_responder_if;
  import dm_pkg::*;
  logic [15:0]          addr;
  logic                 re;
  logic                 we;
  logic [DM_WORD_W-1:0] wrt_data;
  logic [DM_WORD_W-1:0] rd_data;
  logic                 stall;
  logic                 done;
  logic                 err;

  modport master (output addr, re, we, wrt_data,
                  input  rd_data, stall, done, err);
  modport slave  (input  addr, re, we, wrt_data,
                  output rd_data, stall, done, err);
endinterface

// File: rtl/dm_array.sv
// Single-port 2^ADDR_W x DM_WORD_W synchronous RAM with a registered read port.
//   clk, rst : clock; rst clears only the read register, never the array
//   we       : write wdata to mem[addr] on this edge
//   re       : load mem[addr] into rdata on this edge; rdata holds otherwise
//   addr     : word address
//   wdata    : write data
//   rdata    : registered read data
module dm_array
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DM_WORD_W-1:0] wdata,
  output logic [DM_WORD_W-1:0] rdata
);
  logic [DM_WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the CPU load/store port.
// An accepted request stalls the CPU for LATENCY cycles (acceptance cycle
// included), commits on the edge entering DONE, then pulses done for one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave end of the CPU load/store port
// Parameters: ADDR_W word-address bits used (upper addr bits ignored),
//             LATENCY 1..DM_LAT_MAX cycles from acceptance to completion.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  dm_responder_if.slave  bus
);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dm_state_e            state, nxt;
  logic [3:0]           cnt;
  logic [ADDR_W-1:0]    lat_addr;
  logic [DM_WORD_W-1:0] lat_data;
  logic                 lat_wr;
  logic                 err_q;
  logic                 stall, done, req;

  logic                 commit, from_in, c_wr;
  logic [ADDR_W-1:0]    c_addr;
  logic [DM_WORD_W-1:0] c_data;

  logic                 unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[15:ADDR_W];

  assign req = bus.re | bus.we;

  always_comb begin
    nxt   = state;
    stall = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: if (req) begin
        stall = 1'b1;
        nxt   = (LATENCY == 1) ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) nxt = DONE;
      end
      DONE: begin
        // request still on the bus is the one just serviced
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the acceptance edge, so the access
  // comes straight from the bus; otherwise from the request latch.
  // Reset on the commit edge drops the access.
  assign commit  = (nxt == DONE) && !rst;
  assign from_in = (state == IDLE);
  assign c_wr    = from_in ? bus.we                 : lat_wr;
  assign c_addr  = from_in ? bus.addr[ADDR_W-1:0]   : lat_addr;
  assign c_data  = from_in ? bus.wrt_data           : lat_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        lat_addr <= bus.addr[ADDR_W-1:0];
        lat_data <= bus.wrt_data;
        lat_wr   <= bus.we;          // re&we resolves to a write
        cnt      <= CNT_INIT;
        err_q    <= err_q | (bus.re & bus.we);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  dm_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (commit & c_wr),
    .re    (commit & ~c_wr),
    .addr  (c_addr),
    .wdata (c_data),
    .rdata (bus.rd_data)
  );

  assign bus.stall = stall;
  assign bus.done  = done;
  assign bus.err   = err_q;
endmodule
